spi_flash_reader: RTL and testbench
===================================

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning i_clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter FLASH_OFFSET, default 24'h000000, meaning the flash byte address that maps to CPU window offset 0.
REQ-003 SHALL have port i_clk, in, 1, single system clock; all logic rising-edge.
REQ-004 SHALL have port i_rst_n, in, 1, synchronous active-low reset.
REQ-005 SHALL have port i_spi_ce, in, 1, active-high flash window select from the address decoder.
REQ-006 SHALL have port i_address, in, 16, 6809 address bus.
REQ-007 SHALL have port i_FT_CS, in, 1, FT2232 flash select; low means the FT2232 owns the flash.
REQ-008 SHALL have port i_spi_miso, in, 1, flash serial data out.
REQ-009 SHALL have port o_spi_cs_n, out, 1, flash chip select, active low.
REQ-010 SHALL have port o_spi_sclk, out, 1, SPI clock, mode 0.
REQ-011 SHALL have port o_spi_mosi, out, 1, serial data to flash.
REQ-012 SHALL have port o_spi_oe, out, 1, pad drive enable for cs_n/sclk/mosi.
REQ-013 SHALL have port o_data, out, 8, last byte read.
REQ-014 SHALL have port o_data_valid, out, 1, one-cycle pulse when o_data updates.
REQ-015 SHALL have port o_busy, out, 1, transaction in progress.
REQ-016 SHALL have port o_mrdy, out, 1, 6809 MRDY; low stretches the CPU cycle.

Function
REQ-017 SHALL implement states IDLE, CMD, ADDR, DATA, DONE.
REQ-018 Start condition SHALL be i_spi_ce=1 in the current cycle, registered i_spi_ce=0 from the previous cycle, state IDLE, and i_FT_CS=1.
REQ-019 On start, the block SHALL latch flash address = (FLASH_OFFSET + i_address[11:0]) mod 2^24 and enter CMD at the same edge with o_spi_cs_n=0, o_spi_sclk=0, and o_spi_mosi=MSB of command 8'h03.
REQ-020 Each SPI bit SHALL last 2*CLK_DIV cycles: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-021 MOSI SHALL change only on the edge that drives SCLK 1->0 or on the start edge, and SHALL be sent MSB first.
REQ-022 MISO SHALL be sampled on the i_clk edge that drives SCLK 0->1, MSB first, during DATA only.
REQ-023 Sequencing SHALL be CMD for 8 bits (8'h03), then ADDR for 24 bits, then DATA for 8 bits, with MOSI=0 during DATA, counted by a bit counter.
REQ-024 After the last DATA bit's high phase, the block SHALL enter DONE: o_spi_cs_n=1, SCLK=0, o_data=shifted byte, o_data_valid=1 for exactly one cycle, then IDLE on the next edge.
REQ-025 Latency SHALL be o_data_valid asserted exactly 80*CLK_DIV cycles after the start edge (160 for CLK_DIV=2).
REQ-026 o_busy SHALL be 1 in CMD, ADDR, DATA, and DONE, and 0 in IDLE.
REQ-027 o_mrdy SHALL be combinational and equal to NOT(o_busy OR start condition) AND NOT(i_spi_ce AND i_FT_CS=0).
REQ-028 o_spi_oe SHALL equal i_FT_CS; when 0, the block SHALL not start and the pads SHALL float.
REQ-029 If i_FT_CS falls during CMD, ADDR, or DATA, the block SHALL abort at the next edge: state IDLE, o_spi_cs_n=1, SCLK=0, no o_data_valid, o_data unchanged.
REQ-030 i_spi_ce remaining high after DONE SHALL NOT retrigger; a new read requires i_spi_ce to go low for at least one cycle.
REQ-031 i_spi_ce falling mid-transaction SHALL NOT abort; the read completes and o_data updates.
REQ-032 i_spi_ce rising while busy SHALL be ignored (no queuing).
REQ-033 i_address changes after the start edge SHALL NOT affect the transaction in progress.

Reset
REQ-034 With i_rst_n=0 at an edge, the block SHALL go to state IDLE with o_spi_cs_n=1, o_spi_sclk=0, o_spi_mosi=0, o_data=8'h00, o_data_valid=0, o_busy=0, counters=0, and registered i_spi_ce=0.
REQ-035 Reset mid-transaction SHALL take effect at that edge with no o_data_valid pulse; the first start is possible on the edge after i_rst_n returns high.

Verification
REQ-036 Basic read: CLK_DIV=2, address 16'h3123, flash model returns 8'hA5 -> MOSI stream 03 00 01 23; o_data=8'hA5; o_data_valid single pulse 160 cycles after start; o_mrdy low throughout.
REQ-037 Offset and wrap: FLASH_OFFSET=24'hFFFF00, address 16'h3100 -> address bytes 00 00 00 sent (mod 2^24 wrap).
REQ-038 FT2232 ownership: i_FT_CS=0 with i_spi_ce pulsed -> no CS activity, o_spi_oe=0, o_mrdy=0 while selected. i_FT_CS dropped at bit 20 -> abort; CS high next cycle; o_data holds the prior value.
REQ-039 Held select: i_spi_ce held high 400 cycles -> exactly one transaction. Low 1 cycle then high -> second transaction.
REQ-040 Reset mid-read: i_rst_n=0 during DATA bit 3 -> all outputs at reset values next edge, no valid pulse, o_data=8'h00.
REQ-041 Divider sweep: CLK_DIV=1 and CLK_DIV=5 -> SCLK high/low widths 1 and 5 cycles; latency 80 and 400 cycles.

Source files
------------

// File: rtl/spi_flash_reader.sv
// Memory-mapped SPI flash reader: a 6809 access to the flash window issues a
// 03h READ of one byte and holds MRDY low until the byte has been shifted in.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV      = 2,
  parameter logic [23:0] FLASH_OFFSET = 24'h000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_spi_ce,
  input  logic [15:0] i_address,
  input  logic        i_FT_CS,
  input  logic        i_spi_miso,
  output logic        o_spi_cs_n,
  output logic        o_spi_sclk,
  output logic        o_spi_mosi,
  output logic        o_spi_oe,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_busy,
  output logic        o_mrdy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

  localparam logic [7:0] READ_CMD      = 8'h03;
  localparam logic [7:0] DIV_LAST      = 8'(CLK_DIV - 1);
  localparam logic [5:0] LAST_CMD_BIT  = 6'd7;
  localparam logic [5:0] LAST_ADDR_BIT = 6'd31;
  localparam logic [5:0] LAST_DATA_BIT = 6'd39;

  state_t      state_q, state_d;
  logic        ce_q, ce_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;

  logic        start;
  logic [23:0] flash_addr;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^i_address[15:12];
  assign flash_addr     = FLASH_OFFSET + {12'h000, i_address[11:0]};
  assign start          = i_spi_ce && !ce_q && (state_q == IDLE) && i_FT_CS;

  always_comb begin
    state_d = state_q;
    ce_d    = i_spi_ce;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CMD;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = READ_CMD[7];
          tx_d    = {READ_CMD, flash_addr};
          bit_d   = '0;
          div_d   = '0;
        end
      end
      CMD, ADDR, DATA: begin
        if (!i_FT_CS) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (state_q == DATA) rx_d = {rx_q[6:0], i_spi_miso};
          end else begin
            bit_d = bit_q + 6'd1;
            if (bit_q == LAST_DATA_BIT) begin
              state_d = DONE;
              cs_n_d  = 1'b1;
              sclk_d  = 1'b0;
              mosi_d  = 1'b0;
              data_d  = rx_q;
              valid_d = 1'b1;
            end else begin
              // tx_q runs out of ones after the address, so DATA sends zeros
              sclk_d = 1'b0;
              tx_d   = {tx_q[30:0], 1'b0};
              mosi_d = tx_q[30];
              if (bit_q == LAST_CMD_BIT)  state_d = ADDR;
              if (bit_q == LAST_ADDR_BIT) state_d = DATA;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        bit_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ce_q    <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_spi_cs_n   = cs_n_q;
  assign o_spi_sclk   = sclk_q;
  assign o_spi_mosi   = mosi_q;
  assign o_spi_oe     = i_FT_CS;
  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_busy       = (state_q != IDLE);
  assign o_mrdy       = !(o_busy || start) && !(i_spi_ce && !i_FT_CS);

endmodule

// File: tb/tb_spi_flash_reader.sv
// Four reader instances (different dividers/offsets) share CPU-side stimulus;
// each has a timing-level model of the SPI frame and its own flash responder.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        ft = 1'b1;
  logic [15:0] addr = '0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          armed = 1'b0;

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc <= cyc + 1; end

  task automatic chk(input int inst, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cfg%0d %s actual=%0h required=%0h", inst, name, act, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h87;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int D = (g == 2) ? 1 : (g == 3) ? 5 : 2;
    localparam logic [23:0] OFF = (g == 1) ? 24'hFFFF00 : (g == 2) ? 24'h5A5A5A : 24'h000000;
    localparam int TOTAL = 80 * D;

    logic       miso = 1'b0;
    logic       cs_n, sclk, mosi, oe, dv, busy, mrdy;
    logic [7:0] data;

    spi_flash_reader #(.CLK_DIV(D), .FLASH_OFFSET(OFF)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_spi_ce(ce), .i_address(addr), .i_FT_CS(ft),
      .i_spi_miso(miso), .o_spi_cs_n(cs_n), .o_spi_sclk(sclk), .o_spi_mosi(mosi),
      .o_spi_oe(oe), .o_data(data), .o_data_valid(dv), .o_busy(busy), .o_mrdy(mrdy)
    );

    // Model: a read is "active" from its start window t0 through t0+TOTAL.
    bit          m_act = 1'b0;
    bit          m_ceprev = 1'b0;
    int          m_t0 = 0;
    logic [23:0] m_addr = '0;
    logic [7:0]  m_data = '0;

    initial begin : model
      bit st;
      int e;
      forever begin
        @(posedge clk);
        if (!rst_n) begin
          m_act = 1'b0; m_ceprev = 1'b0; m_data = 8'h00;
        end else begin
          st = ce && !m_ceprev && !m_act && ft;
          if (m_act) begin
            e = cyc - m_t0;
            if (e >= TOTAL) m_act = 1'b0;
            else if (!ft) m_act = 1'b0;
            else if (e == TOTAL - 1) m_data = flash_byte(m_addr);
          end
          if (st) begin
            m_act  = 1'b1;
            m_t0   = cyc + 1;
            m_addr = OFF + {12'h000, addr[11:0]};
          end
          m_ceprev = ce;
        end
      end
    end

    // Flash responder: correct bit only in the window before each DATA rising edge.
    initial begin : flash
      int e;
      logic [7:0] fb;
      forever begin
        @(posedge clk);
        #1;
        e = cyc - m_t0;
        if (m_act && e >= 64 * D && e < TOTAL && (e % (2 * D)) == D - 1) begin
          fb   = flash_byte(m_addr);
          miso = fb[7 - (e / (2 * D) - 32)];
        end else begin
          miso = 1'($urandom_range(0, 1));
        end
      end
    end

    initial begin : compare
      int e;
      bit x_busy, x_cs_n, x_sclk, x_valid, st_now, x_mrdy;
      logic [39:0] frame;
      forever begin
        @(negedge clk);
        if (armed) begin
          e      = cyc - m_t0;
          frame  = {8'h03, m_addr, 8'h00};
          x_busy = m_act;
          if (m_act && e < TOTAL) begin
            x_cs_n = 1'b0; x_sclk = (e % (2 * D)) >= D; x_valid = 1'b0;
            chk(g, "mosi", mosi, frame[39 - e / (2 * D)]);
          end else if (m_act) begin
            x_cs_n = 1'b1; x_sclk = 1'b0; x_valid = 1'b1;
          end else begin
            x_cs_n = 1'b1; x_sclk = 1'b0; x_valid = 1'b0;
          end
          st_now = ce && !m_ceprev && !m_act && ft;
          x_mrdy = !(m_act || st_now) && !(ce && !ft);
          chk(g, "cs_n", cs_n, x_cs_n);
          chk(g, "sclk", sclk, x_sclk);
          chk(g, "valid", dv, x_valid);
          chk(g, "busy", busy, x_busy);
          chk(g, "data", data, m_data);
          chk(g, "mrdy", mrdy, x_mrdy);
          chk(g, "oe", oe, ft);
        end
      end
    end

    // Observations for the hand-computed expectations.
    int          vcount = 0, lat = 0, t_start = 0;
    int          hi_min = 9999, hi_max = 0, lo_min = 9999, lo_max = 0;
    logic [39:0] stream = '0;

    initial begin : monitor
      int  hi_run, lo_run;
      logic busy_prev, sclk_prev;
      hi_run = 0; lo_run = 0; busy_prev = 1'b0; sclk_prev = 1'b0;
      forever begin
        @(negedge clk);
        if (busy === 1'b1 && busy_prev !== 1'b1) t_start = cyc;
        if (cs_n === 1'b0 && sclk === 1'b1 && sclk_prev === 1'b0) stream = {stream[38:0], mosi};
        if (vcount == 0) begin
          if (sclk === 1'b1) hi_run++;
          else if (hi_run != 0) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            hi_run = 0;
          end
          if (cs_n === 1'b0 && sclk === 1'b0) lo_run++;
          else if (sclk === 1'b1 && lo_run != 0) begin
            if (lo_run < lo_min) lo_min = lo_run;
            if (lo_run > lo_max) lo_max = lo_run;
            lo_run = 0;
          end else if (cs_n === 1'b1) lo_run = 0;
        end
        if (dv === 1'b1) begin vcount++; lat = cyc - t_start; end
        busy_prev = busy;
        sclk_prev = sclk;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_idle();
    return !cfg[0].busy && !cfg[1].busy && !cfg[2].busy && !cfg[3].busy &&
           !cfg[0].m_act && !cfg[1].m_act && !cfg[2].m_act && !cfg[3].m_act;
  endfunction

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!all_idle() && n < limit) begin tick(); n++; end
    chk(-1, "idle_wait", all_idle(), 1);
  endtask

  task automatic start_read(input logic [15:0] a);
    addr = a; ce = 1'b1;
    tick();
    ce = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    armed = 1'b1;
    tick();
    @(negedge clk);
    chk(0, "rst_cs_n", cfg[0].cs_n, 1'b1);
    chk(0, "rst_sclk", cfg[0].sclk, 1'b0);
    chk(0, "rst_mosi", cfg[0].mosi, 1'b0);
    chk(0, "rst_data", cfg[0].data, 8'h00);
    chk(0, "rst_valid", cfg[0].dv, 1'b0);
    chk(0, "rst_busy", cfg[0].busy, 1'b0);
    tick();
    rst_n = 1'b1;

    // Basic read, first transaction on every instance
    start_read(16'h3123);
    wait_idle(600);
    chk(0, "stream", cfg[0].stream, 40'h03_000123_00);
    chk(0, "byte", cfg[0].data, 8'hA5);
    chk(0, "latency", cfg[0].lat, 160);
    chk(1, "byte", cfg[1].data, 8'hA4);
    chk(2, "byte", cfg[2].data, 8'hFB);
    chk(2, "latency", cfg[2].lat, 80);
    chk(3, "latency", cfg[3].lat, 400);
    chk(2, "hi_min", cfg[2].hi_min, 1);
    chk(2, "hi_max", cfg[2].hi_max, 1);
    chk(2, "lo_max", cfg[2].lo_max, 1);
    chk(3, "hi_min", cfg[3].hi_min, 5);
    chk(3, "hi_max", cfg[3].hi_max, 5);
    chk(3, "lo_min", cfg[3].lo_min, 5);
    chk(3, "lo_max", cfg[3].lo_max, 5);

    // Offset wrap
    tick();
    start_read(16'h3100);
    wait_idle(600);
    chk(1, "stream_wrap", cfg[1].stream, 40'h03_000000_00);
    chk(1, "byte_wrap", cfg[1].data, 8'h87);
    chk(0, "byte2", cfg[0].data, 8'h86);

    // FT2232 owns the flash
    ft = 1'b0; ce = 1'b1;
    tick();
    @(negedge clk);
    chk(0, "ft_mrdy", cfg[0].mrdy, 1'b0);
    chk(0, "ft_oe", cfg[0].oe, 1'b0);
    chk(0, "ft_cs_n", cfg[0].cs_n, 1'b1);
    tick(); tick();
    ce = 1'b0; tick();
    ft = 1'b1; tick();
    chk(0, "ft_busy", cfg[0].busy, 1'b0);

    // Abort at bit 20
    start_read(16'h0456);
    repeat (80) tick();
    ft = 1'b0;
    tick();
    @(negedge clk);
    chk(0, "abort_cs_n", cfg[0].cs_n, 1'b1);
    chk(0, "abort_busy", cfg[0].busy, 1'b0);
    chk(0, "abort_data", cfg[0].data, 8'h86);
    ft = 1'b1;
    wait_idle(600);
    chk(0, "abort_vcount", cfg[0].vcount, 2);

    // Held select, then a one-cycle gap
    addr = 16'h0777; ce = 1'b1;
    repeat (400) tick();
    chk(0, "held_vcount", cfg[0].vcount, 3);
    ce = 1'b0; tick();
    ce = 1'b1;
    wait_idle(600);
    ce = 1'b0;
    tick();
    chk(0, "regap_vcount", cfg[0].vcount, 4);

    // Reset during DATA bit 3
    start_read(16'h0ABC);
    repeat (141) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk(0, "mrst_data", cfg[0].data, 8'h00);
    chk(0, "mrst_cs_n", cfg[0].cs_n, 1'b1);
    chk(0, "mrst_sclk", cfg[0].sclk, 1'b0);
    chk(0, "mrst_mosi", cfg[0].mosi, 1'b0);
    chk(0, "mrst_busy", cfg[0].busy, 1'b0);
    chk(0, "mrst_valid", cfg[0].dv, 1'b0);
    rst_n = 1'b1;
    tick();
    chk(0, "mrst_vcount", cfg[0].vcount, 4);

    // Random traffic against the model
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 29) == 0) ce = ~ce;
      addr  = 16'($urandom);
      ft    = ($urandom_range(0, 299) != 0);
      rst_n = ($urandom_range(0, 999) != 0);
      tick();
    end
    ce = 1'b0; ft = 1'b1; rst_n = 1'b1;
    wait_idle(600);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
